decoder_3x8_stream: RTL and testbench

Sequential counterpart of the team's 8x3 encoder. Accepts a stream of 3-bit codes over a valid/ready handshake, buffers them in a small FIFO, and emits the matching 8-bit one-hot word from a registered output stage with its own valid/ready handshake. A built-in sweep mode self-generates codes 0..7 in order, so downstream logic (including an encoder) can be exercised for round-trip checks.

---
 rtl/decoder_3x8_stream.sv | 184 ++++++++++++++++++
 tb/tb_decoder_3x8_stream.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_3x8_stream.sv
`default_nettype none
// ============================================================================
// Module      : decoder_3x8_stream
// Description : Streaming 3-to-8 one-hot decoder. Input codes arrive over a
//               valid/ready handshake and are buffered in a DEPTH-entry FIFO.
//               A registered output stage presents the one-hot word with its
//               own valid/ready handshake. A sweep mode generates the words
//               8'h01..8'h80 in order so that a downstream encoder can be
//               checked round-trip.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               in_valid/in_ready - input handshake, in_code[2:0] payload
//               out_valid/out_ready - output handshake, out_d[7:0] one-hot
//               level[AW:0]       - FIFO occupancy, 0..DEPTH
//               sweep_start       - request a sweep (only taken when idle)
//               sweep_busy        - sweep in progress
//               dec_cnt[15:0]     - saturating count of accepted output words
//                                   (present only when DECODE_CNT_EN is defined)
// Options     : DECODE_CNT_EN     - adds the dec_cnt port and counter
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_3x8_stream #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_d,
  output logic [AW:0]   level,
  input  logic          sweep_start,
  output logic          sweep_busy
`ifdef DECODE_CNT_EN
  ,
  output logic [15:0]   dec_cnt
`endif
);

  localparam logic [0:0]  c_st_normal = 1'b0;
  localparam logic [0:0]  c_st_sweep  = 1'b1;
  localparam logic [AW:0] c_full      = (AW+1)'(DEPTH);

  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [2:0]    r_sweep_cnt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_accept;
  logic w_sweeping;
  logic w_sweep_done;
  logic w_sweep_load;

  assign w_full     = (r_count == c_full);
  assign w_empty    = (r_count == '0);
  assign w_sweeping = (r_state == c_st_sweep);
  assign w_push     = in_valid && in_ready;
  assign w_accept   = out_valid && out_ready;
  // Normal-mode load: output slot free (or being freed) and data waiting.
  assign w_pop      = (!out_valid || out_ready) && !w_empty && !w_sweeping;
  // The 8'h80 word is the last of a sweep; its acceptance ends the sweep
  // and must not trigger another load.
  assign w_sweep_done = w_sweeping && w_accept && out_d[7];
  assign w_sweep_load = w_sweeping && (!out_valid || out_ready) && !w_sweep_done;

  assign level = r_count;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_normal;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state. A sweep only starts from a fully idle block; a request
  // at any other time is dropped rather than remembered.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_normal: begin
        if (sweep_start && w_empty && !out_valid) begin
          w_state_nxt = c_st_sweep;
        end
      end
      c_st_sweep: begin
        if (w_sweep_done) begin
          w_state_nxt = c_st_normal;
        end
      end
      default: w_state_nxt = c_st_normal;
    endcase
  end

  // FSM: outputs. in_ready ignores a same-cycle pop to keep it registered-only.
  always_comb begin
    sweep_busy = w_sweeping;
    in_ready   = !w_full && !w_sweeping;
  end

  // --------------------------------------------------------------------------
  // FIFO storage and pointers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output stage. out_d is forced to zero whenever the stage is empty.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_d     <= 8'h00;
    end else if (w_pop) begin
      out_valid <= 1'b1;
      out_d     <= 8'h01 << r_mem[r_rd_ptr];
    end else if (w_sweep_load) begin
      out_valid <= 1'b1;
      out_d     <= 8'h01 << r_sweep_cnt;
    end else if (w_accept) begin
      out_valid <= 1'b0;
      out_d     <= 8'h00;
    end
  end

  // Sweep counter: index of the next sweep word; wraps to 0 after the
  // eighth load, and is explicitly cleared when the sweep completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sweep_cnt <= 3'd0;
    end else if (w_sweep_done) begin
      r_sweep_cnt <= 3'd0;
    end else if (w_sweep_load) begin
      r_sweep_cnt <= r_sweep_cnt + 3'd1;
    end
  end

`ifdef DECODE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt <= 16'h0000;
    end else if (w_accept && (dec_cnt != 16'hFFFF)) begin
      dec_cnt <= dec_cnt + 16'h0001;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_decoder_3x8_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_3x8_stream
// Description : Self-checking bench for decoder_3x8_stream. Directed
//               scenarios plus a randomized run compared against a
//               queue-based transaction model of the block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_3x8_stream;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_code = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_d;
  logic [AW:0] level;
  logic        sweep_start = 1'b0;
  logic        sweep_busy;
`ifdef DECODE_CNT_EN
  logic [15:0] dec_cnt;
`endif

  always #5 clk = ~clk;

  decoder_3x8_stream #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_code     (in_code),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_d       (out_d),
    .level       (level),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy)
`ifdef DECODE_CNT_EN
    ,
    .dec_cnt     (dec_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level reference: queue of buffered codes, one output slot,
  // a sweep flag with the index of the next sweep word, and a transfer count.
  int         m_q[$];
  bit         m_valid = 1'b0;
  logic [7:0] m_d     = 8'h00;
  bit         m_sweep = 1'b0;
  int         m_idx   = 0;
  int         m_cnt   = 0;

  task automatic model_update();
    bit acc;
    bit rdy_in;
    bit ld;
    bit st;
    int c;
    if (rst) begin
      m_q.delete();
      m_valid = 1'b0; m_d = 8'h00; m_sweep = 1'b0; m_idx = 0; m_cnt = 0;
      return;
    end
    acc    = m_valid && out_ready;
    rdy_in = (m_q.size() < DEPTH) && !m_sweep;
    if (acc && m_cnt < 65535) m_cnt++;
    if (!m_sweep) begin
      ld = (!m_valid || out_ready) && (m_q.size() > 0);
      st = sweep_start && (m_q.size() == 0) && !m_valid;
      if (ld) begin
        c = m_q.pop_front();
        m_d = 8'h01 << c; m_valid = 1'b1;
      end else if (acc) begin
        m_d = 8'h00; m_valid = 1'b0;
      end
      if (st) begin m_sweep = 1'b1; m_idx = 0; end
    end else begin
      if (acc && m_d == 8'h80) begin
        m_sweep = 1'b0; m_valid = 1'b0; m_d = 8'h00; m_idx = 0;
      end else if (!m_valid || out_ready) begin
        m_d = 8'h01 << m_idx; m_idx++; m_valid = 1'b1;
      end
    end
    if (in_valid && rdy_in) m_q.push_back(int'(in_code));
  endtask

  // One clock: model advances with the inputs seen at the edge; outputs are
  // sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sweep_start = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_code = 3'd5; out_ready = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_d !== 8'h00) begin bad++; $display("FAIL reset_out_d got=%h exp=00", out_d); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (sweep_busy !== 1'b0) begin bad++; $display("FAIL reset_sweep_busy got=%b exp=0", sweep_busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef DECODE_CNT_EN
    total++; if (dec_cnt !== 16'h0000) begin bad++; $display("FAIL reset_dec_cnt got=%h exp=0000", dec_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    apply_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      in_valid = (k <= 4);
      in_code  = 3'(k - 1);
      tick();
      e = (k >= 2 && k <= 5) ? (8'h01 << (k - 2)) : 8'h00;
      total++; if (out_d !== e) begin bad++; $display("FAIL b2b_out_d cyc=%0d got=%h exp=%h", k, out_d, e); end
      total++; if (out_valid !== (e != 8'h00)) begin bad++; $display("FAIL b2b_out_valid cyc=%0d got=%b exp=%b", k, out_valid, e != 8'h00); end
      total++; if (level > 3'd1) begin bad++; $display("FAIL b2b_level cyc=%0d got=%0d exp<=1", k, level); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] seq[5] = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h00};
    logic [2:0] codes[5] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_code = codes[i];
      tick();
    end
    // FIFO now holds 6,7,0,1 behind 5 in the output stage; offer code 2.
    in_code = 3'd2;
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
      tick();
      total++; if (level !== 3'd4) begin bad++; $display("FAIL bp_level got=%0d exp=4", level); end
      total++; if (out_d !== 8'h20 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold got=%h/%b exp=20/1", out_d, out_valid); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (out_d !== seq[i]) begin bad++; $display("FAIL bp_drain idx=%0d got=%h exp=%h", i, out_d, seq[i]); end
    end
    in_valid = 1'b1; in_code = 3'd2;
    tick();
    in_valid = 1'b0;
    total++; if (level !== 3'd1) begin bad++; $display("FAIL bp_repush_level got=%0d exp=1", level); end
    tick();
    total++; if (out_d !== 8'h04) begin bad++; $display("FAIL bp_repush_out got=%h exp=04", out_d); end
  endtask

  task automatic test_wrap();
    int codes[11];
    int exp_q[$];
    int recv = 0;
    int cyc  = 0;
    logic [7:0] e;
    for (int i = 0; i < 11; i++) codes[i] = int'($urandom_range(0, 7));
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_code = 3'(codes[i]); exp_q.push_back(codes[i]);
      tick();
    end
    total++; if (level !== 3'd2) begin bad++; $display("FAIL wrap_prefill_level got=%0d exp=2", level); end
    out_ready = 1'b1;
    for (int i = 3; i < 11; i++) begin
      in_code = 3'(codes[i]);
      if (out_valid) begin
        e = 8'h01 << exp_q.pop_front();
        recv++;
        total++; if (out_d !== e) begin bad++; $display("FAIL wrap_data idx=%0d got=%h exp=%h", recv, out_d, e); end
      end
      exp_q.push_back(codes[i]);
      tick();
      total++; if (level !== 3'd2) begin bad++; $display("FAIL wrap_level idx=%0d got=%0d exp=2", i, level); end
    end
    in_valid = 1'b0;
    while (recv < 11 && cyc < 30) begin
      if (out_valid && exp_q.size() > 0) begin
        e = 8'h01 << exp_q.pop_front();
        recv++;
        total++; if (out_d !== e) begin bad++; $display("FAIL wrap_drain idx=%0d got=%h exp=%h", recv, out_d, e); end
      end
      tick();
      cyc++;
    end
    total++; if (recv != 11) begin bad++; $display("FAIL wrap_count got=%0d exp=11", recv); end
  endtask

  task automatic test_sweep();
    int k = 0;
    int cyc = 0;
    bit fire;
    bit pv;
    logic [7:0] pd;
    apply_reset();
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    total++; if (sweep_busy !== 1'b1) begin bad++; $display("FAIL sweep_enter got=%b exp=1", sweep_busy); end
    while (k < 8 && cyc < 60) begin
      out_ready = (cyc % 2 == 0);
      in_valid  = 1'b1;
      in_code   = 3'($urandom_range(0, 7));
      pv = out_valid; pd = out_d;
      fire = out_valid && out_ready;
      if (fire) begin
        total++; if (out_d !== (8'h01 << k)) begin bad++; $display("FAIL sweep_word k=%0d got=%h exp=%h", k, out_d, 8'h01 << k); end
        k++;
      end
      tick();
      cyc++;
      if (pv && !fire) begin
        total++; if (out_d !== pd || out_valid !== 1'b1) begin bad++; $display("FAIL sweep_hold got=%h/%b exp=%h/1", out_d, out_valid, pd); end
      end
      if (k < 8) begin
        total++; if (sweep_busy !== 1'b1 || in_ready !== 1'b0 || level !== 3'd0) begin
          bad++; $display("FAIL sweep_busy_state got=%b/%b/%0d exp=1/0/0", sweep_busy, in_ready, level);
        end
      end
    end
    in_valid = 1'b0;
    total++; if (k != 8) begin bad++; $display("FAIL sweep_timeout got=%0d exp=8", k); end
    total++; if (sweep_busy !== 1'b0 || out_valid !== 1'b0 || out_d !== 8'h00 || in_ready !== 1'b1) begin
      bad++; $display("FAIL sweep_exit got=%b/%b/%h/%b exp=0/0/00/1", sweep_busy, out_valid, out_d, in_ready);
    end
  endtask

  task automatic test_sweep_ignored_and_reset();
    logic [7:0] seq[3] = '{8'h08, 8'h10, 8'h20};
    int cyc = 0;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      in_valid = 1'b1; in_code = 3'(i);
      tick();
    end
    in_valid = 1'b0;
    total++; if (level !== 3'd2) begin bad++; $display("FAIL ign_level got=%0d exp=2", level); end
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    total++; if (sweep_busy !== 1'b0) begin bad++; $display("FAIL ign_sweep_busy got=%b exp=0", sweep_busy); end
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      total++; if (out_d !== seq[j] || out_valid !== 1'b1) begin bad++; $display("FAIL ign_decode idx=%0d got=%h exp=%h", j, out_d, seq[j]); end
      tick();
    end
    total++; if (sweep_busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL ign_not_queued got=%b/%b exp=0/0", sweep_busy, out_valid); end
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    while (out_d !== 8'h08 && cyc < 10) begin
      tick();
      cyc++;
    end
    total++; if (out_d !== 8'h08 || sweep_busy !== 1'b1) begin bad++; $display("FAIL rst_reach_08 got=%h/%b exp=08/1", out_d, sweep_busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0 || out_d !== 8'h00) begin bad++; $display("FAIL rst_mid_out got=%b/%h exp=0/00", out_valid, out_d); end
    total++; if (sweep_busy !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL rst_mid_state got=%b/%0d exp=0/0", sweep_busy, level); end
  endtask

`ifdef DECODE_CNT_EN
  task automatic test_dec_cnt();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_code = 3'($urandom_range(0, 7));
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    total++; if (dec_cnt !== 16'd10) begin bad++; $display("FAIL cnt_10 got=%0d exp=10", dec_cnt); end
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    total++; if (dec_cnt !== 16'd18) begin bad++; $display("FAIL cnt_18 got=%0d exp=18", dec_cnt); end
    in_valid = 1'b1;
    for (int i = 0; i < 65542; i++) begin
      in_code = 3'(i % 8);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    total++; if (dec_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_sat got=%h exp=FFFF", dec_cnt); end
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_code     = 3'($urandom_range(0, 7));
      out_ready   = ($urandom_range(0, 2) != 0);
      sweep_start = ($urandom_range(0, 29) == 0);
      rst         = ($urandom_range(0, 249) == 0);
      tick();
      total++; if (out_valid !== m_valid || out_d !== m_d) begin
        bad++; $display("FAIL rnd_out cyc=%0d got=%b/%h exp=%b/%h", i, out_valid, out_d, m_valid, m_d);
      end
      total++; if (level !== 3'(m_q.size())) begin bad++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", i, level, m_q.size()); end
      total++; if (sweep_busy !== m_sweep) begin bad++; $display("FAIL rnd_sweep cyc=%0d got=%b exp=%b", i, sweep_busy, m_sweep); end
      total++; if (in_ready !== ((m_q.size() < DEPTH) && !m_sweep)) begin
        bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", i, in_ready, (m_q.size() < DEPTH) && !m_sweep);
      end
      if (m_valid) begin
        total++; if ($countones(out_d) != 1) begin bad++; $display("FAIL rnd_onehot cyc=%0d got=%h exp=one-hot", i, out_d); end
      end
    end
    rst = 1'b0; in_valid = 1'b0; sweep_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_sweep();
    test_sweep_ignored_and_reset();
`ifdef DECODE_CNT_EN
    test_dec_cnt();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
